// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states,
// default operand width.
package muldiv_pkg;

  localparam int DEFAULT_DATA_W = 32;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/muldiv_div_core.sv
// Restoring divider datapath on unsigned magnitudes, one quotient bit per step.
module muldiv_div_core
  import muldiv_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder
);

  logic [DATA_W-1:0] remReg;
  logic [DATA_W-1:0] quotReg;
  logic [DATA_W-1:0] divisorReg;
  logic [DATA_W:0]   shifted;
  logic [DATA_W:0]   diff;
  logic              takeBit;

  // The dividend is held in the quotient register and shifted out MSB first.
  assign shifted = {remReg, quotReg[DATA_W-1]};
  assign diff    = shifted - {1'b0, divisorReg};
  assign takeBit = shifted >= {1'b0, divisorReg};

  always_ff @(posedge clk) begin
    if (rst) begin
      remReg     <= '0;
      quotReg    <= '0;
      divisorReg <= '0;
    end else if (load) begin
      remReg     <= '0;
      quotReg    <= dividend;
      divisorReg <= divisor;
    end else if (step) begin
      remReg  <= takeBit ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];
      quotReg <= {quotReg[DATA_W-2:0], takeBit};
    end
  end

  assign quotient  = quotReg;
  assign remainder = remReg;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit; signed ops run on magnitudes with a
// sign fix-up at commit. Divider present only when MULDIV_DIV_EN is defined.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [2:0]        op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic              flush_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  state_t              stateReg, stateNext;
  logic [CNT_W-1:0]    cntReg;
  logic [DATA_W-1:0]   hiReg, loReg;
  logic [DATA_W-1:0]   mcandReg;
  logic [2*DATA_W-1:0] prodReg;
  logic                negProdReg;

  logic                isMulOp, isDivOp, signedOp, skipFix;
  logic                reqValid, accept, mtWrite, lastIter;
  logic [DATA_W-1:0]   aMag, bMag;
  logic [DATA_W:0]     addSum;
  logic [2*DATA_W-1:0] prodFix;
  logic [DATA_W-1:0]   commitHi, commitLo;

  assign isMulOp  = (op_i == OP_MULT) || (op_i == OP_MULTU);
  assign signedOp = (op_i == OP_MULT) || (op_i == OP_DIV);

`ifdef MULDIV_DIV_EN
  // Signed divide-by-zero keeps the raw magnitude result, so no fix-up.
  assign isDivOp = (op_i == OP_DIV) || (op_i == OP_DIVU);
  assign skipFix = isDivOp && (b_i == '0);
`else
  assign isDivOp = 1'b0;
  assign skipFix = 1'b0;
`endif

  assign reqValid = (stateReg == IDLE) && start_i && !flush_i;
  assign accept   = reqValid && (isMulOp || isDivOp);
  assign mtWrite  = reqValid && ((op_i == OP_MTHI) || (op_i == OP_MTLO));
  assign lastIter = cntReg == CNT_W'(DATA_W - 1);

  assign aMag = (signedOp && a_i[DATA_W-1]) ? -a_i : a_i;
  assign bMag = (signedOp && b_i[DATA_W-1]) ? -b_i : b_i;

  // Shift-add step: add multiplicand into the upper half when the current
  // multiplier bit (prodReg LSB) is set, then shift the whole product right.
  assign addSum = {1'b0, prodReg[2*DATA_W-1:DATA_W]}
                + (prodReg[0] ? {1'b0, mcandReg} : '0);

`ifdef MULDIV_DIV_EN
  logic              isDivReg, negRemReg;
  logic [DATA_W-1:0] divQuot, divRem;

  muldiv_div_core #(.DATA_W(DATA_W)) divCore (
    .clk       (clk),
    .rst       (rst),
    .load      (accept && isDivOp),
    .step      (stateReg == RUN),
    .dividend  (aMag),
    .divisor   (bMag),
    .quotient  (divQuot),
    .remainder (divRem)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      isDivReg  <= 1'b0;
      negRemReg <= 1'b0;
    end else if (accept) begin
      isDivReg  <= isDivOp;
      negRemReg <= isDivOp && signedOp && a_i[DATA_W-1] && !skipFix;
    end
  end
`endif

  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      IDLE:    if (accept) stateNext = RUN;
      RUN:     if (flush_i) stateNext = IDLE;
               else if (lastIter) stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    prodFix  = negProdReg ? -prodReg : prodReg;
    commitHi = prodFix[2*DATA_W-1:DATA_W];
    commitLo = prodFix[DATA_W-1:0];
`ifdef MULDIV_DIV_EN
    if (isDivReg) begin
      commitLo = negProdReg ? -divQuot : divQuot;
      commitHi = negRemReg ? -divRem : divRem;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stateReg   <= IDLE;
      cntReg     <= '0;
      hiReg      <= '0;
      loReg      <= '0;
      mcandReg   <= '0;
      prodReg    <= '0;
      negProdReg <= 1'b0;
    end else begin
      stateReg <= stateNext;
      case (stateReg)
        IDLE: begin
          cntReg <= '0;
          if (accept) begin
            mcandReg   <= aMag;
            prodReg    <= {{DATA_W{1'b0}}, bMag};
            negProdReg <= signedOp && (a_i[DATA_W-1] ^ b_i[DATA_W-1]) && !skipFix;
          end
          if (mtWrite && (op_i == OP_MTHI)) hiReg <= a_i;
          if (mtWrite && (op_i == OP_MTLO)) loReg <= a_i;
        end
        RUN: begin
          cntReg  <= cntReg + 1'b1;
          prodReg <= {addSum, prodReg[DATA_W-1:1]};
        end
        DONE: begin
          cntReg <= '0;
          hiReg  <= commitHi;
          loReg  <= commitLo;
        end
        default: cntReg <= '0;
      endcase
    end
  end

  assign busy_o = stateReg == RUN;
  assign done_o = stateReg == DONE;
  assign hi_o   = hiReg;
  assign lo_o   = loReg;

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomised plus directed bench for muldiv_unit (DATA_W=32) against a
// cycle-timed arithmetic reference model.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int DW = 32;
`ifdef MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, start_i, flush_i;
  logic [2:0]    op_i;
  logic [DW-1:0] a_i, b_i;
  logic          busy_o, done_o;
  logic [DW-1:0] hi_o, lo_o;

  int errors = 0;
  int checks = 0;
  bit checkEn = 1'b0;

  muldiv_unit #(.DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i), .a_i(a_i), .b_i(b_i),
    .flush_i(flush_i), .busy_o(busy_o), .done_o(done_o), .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference result as {hi, lo}, straight from the arithmetic definition.
  function automatic logic [63:0] calc(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] res;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    res = '0;
    case (op)
      OP_MULT:  res = 64'(sa * sb);
      OP_MULTU: res = {32'b0, a} * {32'b0, b};
      OP_DIVU:  res = (b == 0) ? {a, 32'hFFFFFFFF} : {a % b, a / b};
      OP_DIV: begin
        if (b == 0) begin
          q = (sa < 0) ? -sa : sa;
          res = {q[31:0], 32'hFFFFFFFF};
        end else begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
      default: res = '0;
    endcase
    return res;
  endfunction

  // Model: phase = cycles since acceptance (0 = idle, 1..DW busy, DW+1 done).
  int          phase = 0;
  logic [31:0] mHi = '0, mLo = '0, pHi = '0, pLo = '0;

  always @(posedge clk) begin
    if (rst) begin
      phase <= 0; mHi <= '0; mLo <= '0;
    end else if (phase == 0) begin
      if (start_i && !flush_i) begin
        if (op_i == OP_MULT || op_i == OP_MULTU ||
            (DIV_EN && (op_i == OP_DIV || op_i == OP_DIVU))) begin
          {pHi, pLo} <= calc(op_i, a_i, b_i);
          phase <= 1;
        end else if (op_i == OP_MTHI) mHi <= a_i;
        else if (op_i == OP_MTLO) mLo <= a_i;
      end
    end else if (phase <= DW) begin
      phase <= flush_i ? 0 : phase + 1;
    end else begin
      mHi <= pHi; mLo <= pLo; phase <= 0;
    end
  end

  always @(negedge clk) begin
    if (checkEn) begin
      chk("busy", busy_o, (phase >= 1 && phase <= DW));
      chk("done", done_o, (phase == DW + 1));
      chk("hi", hi_o, mHi);
      chk("lo", lo_o, mLo);
    end
  end

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk); #1;
    start_i = 1'b1; op_i = op; a_i = a; b_i = b;
    @(posedge clk); #1;
    start_i = 1'b0; op_i = 3'($urandom); a_i = $urandom; b_i = $urandom;
  endtask

  // Counts from the first cycle after acceptance through the first result cycle.
  task automatic measure(output int busyCnt, output int doneAt);
    busyCnt = 0; doneAt = -1;
    for (int k = 1; k <= DW + 2; k++) begin
      @(negedge clk);
      if (busy_o) busyCnt++;
      if (done_o) doneAt = k;
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int busyCnt, doneAt, doneSeen;
    rst = 1'b1; start_i = 1'b0; flush_i = 1'b0; op_i = '0; a_i = '0; b_i = '0;

    chk("model_mult", calc(OP_MULT, 32'hFFFFFFFD, 32'd7), 64'hFFFFFFFF_FFFFFFEB);
    chk("model_multu", calc(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF), 64'hFFFFFFFE_00000001);
    chk("model_div", calc(OP_DIV, 32'hFFFFFFF9, 32'd2), 64'hFFFFFFFF_FFFFFFFD);
    chk("model_divneg1", calc(OP_DIV, 32'h80000000, 32'hFFFFFFFF), 64'h00000000_80000000);

    repeat (2) @(negedge clk);
    chk("rst_busy", busy_o, 0); chk("rst_done", done_o, 0);
    chk("rst_hi", hi_o, 0);     chk("rst_lo", lo_o, 0);
    checkEn = 1'b1;
    #1 rst = 1'b0;

    issue(OP_MULT, 32'hFFFFFFFD, 32'd7);
    measure(busyCnt, doneAt);
    chk("mult_done_cycle", doneAt, 33);
    chk("mult_hi", hi_o, 32'hFFFFFFFF); chk("mult_lo", lo_o, 32'hFFFFFFEB);

    issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    measure(busyCnt, doneAt);
    chk("multu_busy_cycles", busyCnt, 32);
    chk("multu_hi", hi_o, 32'hFFFFFFFE); chk("multu_lo", lo_o, 32'h00000001);

`ifdef MULDIV_DIV_EN
    issue(OP_DIV, 32'hFFFFFFF9, 32'd2);
    measure(busyCnt, doneAt);
    chk("div_lo", lo_o, 32'hFFFFFFFD); chk("div_hi", hi_o, 32'hFFFFFFFF);
    issue(OP_DIVU, 32'd5, 32'd0);
    measure(busyCnt, doneAt);
    chk("divu0_lo", lo_o, 32'hFFFFFFFF); chk("divu0_hi", hi_o, 32'd5);
    issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
    measure(busyCnt, doneAt);
    chk("divovf_lo", lo_o, 32'h80000000); chk("divovf_hi", hi_o, 32'd0);
`else
    issue(OP_DIV, 32'd9, 32'd3);
    measure(busyCnt, doneAt);
    chk("nodiv_busy", busyCnt, 0); chk("nodiv_done", doneAt, -1);
    chk("nodiv_hi", hi_o, 32'hFFFFFFFE); chk("nodiv_lo", lo_o, 32'h00000001);
`endif

    issue(OP_MTHI, 32'h11, 32'd0);
    issue(OP_MTLO, 32'h22, 32'd0);
    @(negedge clk);
    chk("mt_hi", hi_o, 32'h11); chk("mt_lo", lo_o, 32'h22);
    issue(OP_MULT, 32'd6, 32'd7);
    repeat (9) @(negedge clk);
    @(negedge clk); #1 flush_i = 1'b1;
    @(posedge clk); #1 flush_i = 1'b0;
    @(negedge clk);
    chk("flush_busy", busy_o, 0); chk("flush_done", done_o, 0);
    chk("flush_hi", hi_o, 32'h11); chk("flush_lo", lo_o, 32'h22);
    doneSeen = 0;
    repeat (40) begin @(negedge clk); if (done_o) doneSeen = 1; end
    chk("flush_no_done", doneSeen, 0);
    issue(OP_MTHI, 32'h1234, 32'd0);
    @(negedge clk);
    chk("mthi_after_flush", hi_o, 32'h1234); chk("mthi_no_busy", busy_o, 0);
    @(negedge clk); #1;
    start_i = 1'b1; op_i = OP_MTLO; a_i = 32'hDEAD; flush_i = 1'b1;
    @(posedge clk); #1 start_i = 1'b0; flush_i = 1'b0;
    @(negedge clk);
    chk("idle_flush_mtlo", lo_o, 32'h22);

    issue(DIV_EN ? OP_DIVU : OP_MULTU, 32'd100, 32'd7);
    repeat (2) @(negedge clk);
    @(negedge clk); #1 start_i = 1'b1; op_i = OP_MTHI; a_i = 32'hFFFF;
    @(posedge clk); #1 start_i = 1'b0;
    @(negedge clk);
    chk("run_start_ignored", hi_o, 32'h1234);
    @(negedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_busy", busy_o, 0); chk("midrst_done", done_o, 0);
    chk("midrst_hi", hi_o, 0);     chk("midrst_lo", lo_o, 0);
    doneSeen = 0;
    repeat (40) begin @(negedge clk); if (done_o) doneSeen = 1; end
    chk("midrst_no_done", doneSeen, 0);

    for (int c = 0; c < 4000; c++) begin
      @(negedge clk); #1;
      rst     = ($urandom_range(0, 399) == 0);
      start_i = ($urandom_range(0, 3) == 0);
      op_i    = 3'($urandom_range(0, 7));
      a_i     = pick();
      b_i     = pick();
      if (op_i == OP_DIV && b_i == 0) b_i = 32'd3;
      flush_i = ($urandom_range(0, 63) == 0);
    end
    @(negedge clk); #1;
    rst = 1'b0; start_i = 1'b0; flush_i = 1'b0;
    repeat (40) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
